ar_rxa_demod: RTL and testbench

//  Receive end of the AR_TXA analog link. Takes 12-bit ADC samples of the modulated line signal,

---
 rtl/ar_rxa_demod_pkg.sv | 20 ++
 rtl/ar_rxa_demod_if.sv | 14 +
 rtl/ar_rxa_demod_rx_timer.sv | 59 +++++
 rtl/ar_rxa_demod.sv | 120 ++++++++++++
 tb/tb_ar_rxa_demod.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/ar_rxa_demod_pkg.sv
// Frame constants for the AR_TXA/AR_RXA link plus receiver thresholds.
// One source for line-level constants shared by the transmit and receive sides.
package ar_rxa_demod_pkg;
  localparam int NS0       = 2048;
  localparam int DATA_BITS = 31;
  localparam int SPB_DEF   = 100;
  localparam int ACC_W_DEF = 20;
  localparam int DET_THR_DEF  = 64;
  localparam int MIN_E_DEF    = 1024;
  localparam int GAP_BITS_DEF = 8;

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_CHK, ST_GAP} state_e;

  // Magnitude of a 13-bit signed sample, saturated to 12 bits.
  function automatic logic [11:0] abs_sat(input logic signed [12:0] v);
    logic [12:0] m;
    m = v[12] ? 13'(-v) : 13'(v);
    return m[12] ? 12'hFFF : m[11:0];
  endfunction
endpackage

// File: rtl/ar_rxa_demod_if.sv
// ADC sample stream in, decoded word and strobes out. The sampler side drives ce/RXA.
interface ar_rxa_demod_if;
  logic        ce;
  logic [11:0] RXA;
  logic        RXD;
  logic        en_rx;
  logic        T_cp;
  logic [30:0] DAT;
  logic        rdy;
  logic        err;

  modport master (output ce, RXA, input RXD, en_rx, T_cp, DAT, rdy, err);
  modport slave  (input ce, RXA, output RXD, en_rx, T_cp, DAT, rdy, err);
endinterface

// File: rtl/ar_rxa_demod_rx_timer.sv
// Sample-in-bit, bit-interval and post-frame gap counters; all advance only on ce.
// Outputs are combinational decodes of the counters, valid in the ce cycle they flag.
module ar_rxa_demod_rx_timer
  import ar_rxa_demod_pkg::*;
#(
  parameter int SPB      = SPB_DEF,
  parameter int GAP_BITS = GAP_BITS_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ce_i,
  input  logic start_i,
  input  logic run_i,
  input  logic gap_i,
  output logic ce_bit_o,
  output logic last_dat_o,
  output logic last_cp_o,
  output logic gap_done_o
);
  localparam int SW    = $clog2(SPB);
  localparam int GAP_N = GAP_BITS * SPB;
  localparam int GW    = $clog2(GAP_N + 1);
  localparam logic [SW-1:0] SAMP_LAST = SW'(SPB - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_N - 1);

  logic [SW-1:0] samp_q;
  logic [4:0]    idx_q;
  logic [GW-1:0] gap_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_q <= '0;
      idx_q  <= '0;
      gap_q  <= '0;
    end else begin
      // The trigger sample is already sample 0 of the first interval.
      if (start_i) begin
        samp_q <= SW'(1);
        idx_q  <= '0;
      end else if (ce_i && run_i) begin
        if (samp_q == SAMP_LAST) begin
          samp_q <= '0;
          idx_q  <= idx_q + 5'd1;
        end else begin
          samp_q <= samp_q + SW'(1);
        end
      end
      if (!gap_i)
        gap_q <= '0;
      else if (ce_i)
        gap_q <= gap_q + GW'(1);
    end
  end

  assign ce_bit_o   = ce_i && run_i && (samp_q == SAMP_LAST);
  assign last_dat_o = (idx_q == 5'(DATA_BITS - 1));
  assign last_cp_o  = (idx_q == 5'(DATA_BITS));
  assign gap_done_o = ce_i && gap_i && (gap_q == GAP_LAST);
endmodule

// File: rtl/ar_rxa_demod.sv
// Integrate-and-dump demodulator: frame detect, 31 data bits MSB-first, odd check bit.
// rdy/err pulse one clock after the deciding ce; no backpressure, samples qualified by ce.
module ar_rxa_demod
  import ar_rxa_demod_pkg::*;
#(
  parameter int SPB      = SPB_DEF,
  parameter int ACC_W    = ACC_W_DEF,
  parameter int DET_THR  = DET_THR_DEF,
  parameter int MIN_E    = MIN_E_DEF,
  parameter int GAP_BITS = GAP_BITS_DEF
) (
  input logic clk,
  input logic rst_n,
  ar_rxa_demod_if.slave bus
);
  state_e                  state_q;
  logic signed [ACC_W-1:0] s_q, s_d;
  logic        [ACC_W-1:0] e_q, e_d;
  logic [DATA_BITS-1:0]    sh_q, dat_q;
  logic                    par_q, rxd_q, en_rx_q, tcp_q, rdy_q, err_q;

  logic signed [12:0] x;
  logic [11:0]        ax;
  logic               trig, bit_dec, dropout;
  logic               ce_bit, last_dat, last_cp, gap_done;

  assign x       = signed'({1'b0, bus.RXA} - 13'(NS0));
  assign ax      = abs_sat(x);
  assign trig    = (ax >= 12'(DET_THR));
  assign s_d     = s_q + ACC_W'(x);
  assign e_d     = e_q + ACC_W'(ax);
  assign bit_dec = !s_d[ACC_W-1] && (s_d != '0);
  assign dropout = (e_d < ACC_W'(MIN_E));

  ar_rxa_demod_rx_timer #(.SPB(SPB), .GAP_BITS(GAP_BITS)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .ce_i       (bus.ce),
    .start_i    (bus.ce && (state_q == ST_IDLE) && trig),
    .run_i      ((state_q == ST_DATA) || (state_q == ST_CHK)),
    .gap_i      (state_q == ST_GAP),
    .ce_bit_o   (ce_bit),
    .last_dat_o (last_dat),
    .last_cp_o  (last_cp),
    .gap_done_o (gap_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      e_q     <= '0;
      sh_q    <= '0;
      dat_q   <= '0;
      par_q   <= 1'b0;
      rxd_q   <= 1'b0;
      en_rx_q <= 1'b0;
      tcp_q   <= 1'b0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      err_q <= 1'b0;
      if (bus.ce) begin
        case (state_q)
          ST_IDLE: if (trig) begin
            state_q <= ST_DATA;
            en_rx_q <= 1'b1;
            s_q     <= ACC_W'(x);
            e_q     <= ACC_W'(ax);
            par_q   <= 1'b1;
          end
          ST_DATA, ST_CHK: begin
            if (ce_bit) begin
              s_q   <= '0;
              e_q   <= '0;
              rxd_q <= bit_dec;
              if (dropout) begin
                err_q   <= 1'b1;
                en_rx_q <= 1'b0;
                tcp_q   <= 1'b0;
                state_q <= ST_GAP;
              end else if (!last_cp) begin
                sh_q  <= {sh_q[DATA_BITS-2:0], bit_dec};
                par_q <= par_q ^ bit_dec;
                if (last_dat) begin
                  state_q <= ST_CHK;
                  tcp_q   <= 1'b1;
                end
              end else begin
                // par_q holds the check value that makes the total ones count odd.
                if (bit_dec == par_q) begin
                  dat_q <= sh_q;
                  rdy_q <= 1'b1;
                end else begin
                  err_q <= 1'b1;
                end
                en_rx_q <= 1'b0;
                tcp_q   <= 1'b0;
                state_q <= ST_GAP;
              end
            end else begin
              s_q <= s_d;
              e_q <= e_d;
            end
          end
          ST_GAP: if (gap_done) state_q <= ST_IDLE;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.RXD   = rxd_q;
  assign bus.en_rx = en_rx_q;
  assign bus.T_cp  = tcp_q;
  assign bus.DAT   = dat_q;
  assign bus.rdy   = rdy_q;
  assign bus.err   = err_q;
endmodule

// File: tb/tb_ar_rxa_demod.sv
// Drives bipolar-line frames into the demodulator; a monitor scores rdy/err against a queue.
module tb_ar_rxa_demod;
  import ar_rxa_demod_pkg::*;

  localparam int SPB   = 100;
  localparam int GAP_N = 8 * SPB;
  localparam int A     = 1000;

  typedef struct packed {
    logic        is_err;
    logic [30:0] dat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  logic [30:0] last_good = '0;

  ar_rxa_demod_if bus();

  ar_rxa_demod #(.SPB(SPB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every strobe must match the oldest expected frame outcome.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (bus.rdy || bus.err)) begin
        checks++;
        if (bus.rdy && bus.err) begin
          errors++;
          $display("FAIL strobe_excl: rdy and err both high at %0t", $time);
        end else if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe: rdy=%0b err=%0b DAT=%0h at %0t",
                   bus.rdy, bus.err, bus.DAT, $time);
        end else begin
          e = exp_q.pop_front();
          if (bus.err !== e.is_err || bus.DAT !== e.dat) begin
            errors++;
            $display("FAIL frame_result: got err=%0b DAT=%0h expected err=%0b DAT=%0h at %0t",
                     bus.err, bus.DAT, e.is_err, e.dat, $time);
          end
        end
      end
    end
  end

  task automatic drive(input logic [11:0] v);
    @(negedge clk);
    bus.RXA = v;
    bus.ce  = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(12'(NS0));
  endtask

  // drop_iv: line dead from that interval on; hole_iv: 50-clock ce gap mid-interval;
  // abort_iv: reset asserted mid-interval. -1 disables each.
  task automatic send_frame(input logic [30:0] d, input bit flip, input int drop_iv,
                            input int hole_iv, input int abort_iv);
    logic        c, b, bad;
    int          last_iv;
    logic [11:0] v;
    c       = ~(^d) ^ flip;
    bad     = flip || (drop_iv >= 0);
    last_iv = (drop_iv >= 0) ? drop_iv : 31;
    if (abort_iv < 0) exp_q.push_back(bad ? {1'b1, last_good} : {1'b0, d});
    for (int iv = 0; iv <= last_iv; iv++) begin
      b = (iv == 31) ? c : d[30-iv];
      v = (drop_iv >= 0 && iv >= drop_iv) ? 12'(NS0) : (b ? 12'(NS0 + A) : 12'(NS0 - A));
      for (int s = 0; s < SPB; s++) begin
        if (iv == abort_iv && s == 50) begin
          @(negedge clk);
          rst_n   = 1'b0;
          bus.ce  = 1'b0;
          bus.RXA = 12'(NS0);
          #1;
          check("reset_mid_frame", {bus.RXD, bus.en_rx, bus.T_cp, bus.DAT, bus.rdy, bus.err}, '0);
          repeat (3) @(negedge clk);
          rst_n     = 1'b1;
          last_good = '0;
          return;
        end
        if (iv == hole_iv && s == 40) begin
          repeat (50) begin
            @(negedge clk);
            bus.ce  = 1'b0;
            bus.RXA = b ? 12'(NS0 - A) : 12'(NS0 + A);
          end
        end
        @(negedge clk);
        if (iv == 31 && s == 1) begin
          check("T_cp_in_check", bus.T_cp, 1);
          check("en_rx_in_check", bus.en_rx, 1);
          check("RXD_last_data", bus.RXD, d[0]);
        end
        bus.RXA = v;
        bus.ce  = 1'b1;
      end
    end
    @(negedge clk);
    check("strobe_latency", bus.rdy | bus.err, 1);
    check("en_rx_fall", bus.en_rx, 0);
    bus.RXA = 12'(NS0);
    bus.ce  = 1'b1;
    if (!bad) last_good = d;
  endtask

  initial begin
    bus.ce  = 1'b0;
    bus.RXA = 12'(NS0);
    repeat (3) @(negedge clk);
    check("reset_state", {bus.RXD, bus.en_rx, bus.T_cp, bus.DAT, bus.rdy, bus.err}, '0);
    rst_n = 1'b1;
    idle(10);
    check("idle_en_rx", bus.en_rx, 0);

    send_frame(31'h2AAAAAAA, 1'b0, -1, -1, -1); idle(GAP_N + 50);
    send_frame(31'h7FFFFFFF, 1'b0, -1, -1, -1); idle(GAP_N + 50);
    send_frame(31'h00000000, 1'b0, -1, -1, -1); idle(GAP_N + 50);
    send_frame(31'h0ABCDEF1, 1'b0, -1, -1, -1); idle(GAP_N + 50);
    send_frame(31'h12345678, 1'b1, -1, -1, -1); idle(GAP_N + 50);
    send_frame(31'h1F0F00FF, 1'b0, 18, -1, -1); idle(GAP_N + 50);
    send_frame(31'h3C3C3C3C, 1'b0, -1, -1, -1); idle(GAP_N + 50);

    for (int i = 0; i < 10000; i++) begin
      drive(12'(NS0 + ((i * 37) % 81) - 40));
      if (i % 1000 == 999) check("noise_en_rx", bus.en_rx, 0);
    end
    idle(10);

    send_frame(31'h1555AAAA, 1'b0, -1, -1, 15);
    idle(10);
    send_frame(31'h6DB6DB6D, 1'b0, -1, -1, -1); idle(GAP_N + 50);
    send_frame(31'h2468ACE0, 1'b0, -1, 5, -1);  idle(GAP_N + 50);

    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
